// File: rtl/chamber_chain_sequencer_pkg.sv
// Shared types for the chamber chain sequencer: op codes, per-chamber states
// and the power-on op table pattern.
package mfda_seq_pkg;

  typedef enum logic [1:0] {
    OP_MIX    = 2'd0,
    OP_FILTER = 2'd1,
    OP_HEAT   = 2'd2,
    OP_DETECT = 2'd3
  } op_e;

  typedef enum logic [2:0] {
    ST_EMPTY   = 3'd0,
    ST_FILL    = 3'd1,
    ST_PROCESS = 3'd2,
    ST_READY   = 3'd3,
    ST_DRAIN   = 3'd4
  } stage_state_e;

  // Default op for chamber k cycles MIX, FILTER, HEAT, DETECT along the chain.
  function automatic op_e reset_op(input int k);
    logic [31:0] w_k;
    logic [1:0]  w_lo;
    w_k  = k;
    w_lo = w_k[1:0];
    return op_e'(w_lo);
  endfunction

endpackage

// File: rtl/chamber_chain_sequencer_stage.sv
// One chamber of the chain: EMPTY -> FILL -> PROCESS -> READY -> DRAIN -> EMPTY,
// with a shared down-counter timing the valve and process phases.
module chamber_stage_fsm
  import mfda_seq_pkg::*;
#(
  parameter int DWELL_W = 8,
  parameter int CNT_W   = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_fill,
  input  logic               downstream_free,
  input  logic [DWELL_W-1:0] dwell,
  input  logic [CNT_W-1:0]   xfer,
  output stage_state_e       state,
  output logic               valve,
  output logic               ready
);

  stage_state_e     r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             w_cnt_done;

  assign w_cnt_done = (r_cnt == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_EMPTY;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (start_fill) begin
            r_state <= ST_FILL;
            r_cnt   <= xfer - CNT_W'(1);
          end
        end
        ST_FILL: begin
          // A zero dwell skips processing; the plug is ready as soon as it lands.
          if (w_cnt_done) begin
            if (dwell == '0) begin
              r_state <= ST_READY;
            end else begin
              r_state <= ST_PROCESS;
              r_cnt   <= CNT_W'(dwell) - CNT_W'(1);
            end
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        ST_PROCESS: begin
          if (w_cnt_done) r_state <= ST_READY;
          else            r_cnt   <= r_cnt - CNT_W'(1);
        end
        ST_READY: begin
          if (downstream_free) begin
            r_state <= ST_DRAIN;
            r_cnt   <= xfer - CNT_W'(1);
          end
        end
        ST_DRAIN: begin
          if (w_cnt_done) r_state <= ST_EMPTY;
          else            r_cnt   <= r_cnt - CNT_W'(1);
        end
        default: r_state <= ST_EMPTY;
      endcase
    end
  end

  assign state = r_state;
  assign valve = (r_state == ST_FILL);
  assign ready = (r_state == ST_READY);

endmodule

// File: rtl/chamber_chain_sequencer.sv
// Linear chain of NUM_STAGES chambers moving plugs from an injector to a collector,
// with a run-time op/dwell table that may only be rewritten while the chain is idle.
module chamber_chain_sequencer
  import mfda_seq_pkg::*;
#(
  parameter int NUM_STAGES  = 5,
  parameter int DWELL_W     = 8,
  parameter int XFER_CYCLES = 2,
  parameter int STAGE_W     = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cfg_we,
  input  logic [STAGE_W-1:0]      cfg_stage,
  input  logic [1:0]              cfg_op,
  input  logic [DWELL_W-1:0]      cfg_dwell,
  output logic                    cfg_err,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [NUM_STAGES:0]     valve_open,
  output logic [NUM_STAGES-1:0]   stage_busy,
  output logic [2*NUM_STAGES-1:0] stage_op
);

  localparam int XFER_W = $clog2(XFER_CYCLES + 1);
  localparam int CNT_W  = (DWELL_W > XFER_W) ? DWELL_W : XFER_W;
  localparam logic [CNT_W-1:0]   XFER_L   = CNT_W'(XFER_CYCLES);
  localparam logic [STAGE_W:0]   STAGES_L = (STAGE_W + 1)'(NUM_STAGES);

  op_e                r_op    [NUM_STAGES];
  logic [DWELL_W-1:0] r_dwell [NUM_STAGES];
  logic               r_cfg_err;

  stage_state_e          w_state [NUM_STAGES];
  logic [NUM_STAGES-1:0] w_start;
  logic [NUM_STAGES-1:0] w_dn_free;
  logic [NUM_STAGES-1:0] w_valve;
  logic [NUM_STAGES-1:0] w_ready;
  logic                  w_all_empty;
  logic                  w_in_ready;
  logic                  w_cfg_ok;

  always_comb begin
    w_all_empty = 1'b1;
    for (int k = 0; k < NUM_STAGES; k++) begin
      if (w_state[k] != ST_EMPTY) w_all_empty = 1'b0;
    end
  end

  assign w_in_ready = !rst && (w_state[0] == ST_EMPTY);
  assign w_cfg_ok   = cfg_we && w_all_empty && ({1'b0, cfg_stage} < STAGES_L);

  // Table writes land at the same edge a plug is accepted, so that plug sees them.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cfg_err <= 1'b0;
      for (int k = 0; k < NUM_STAGES; k++) begin
        r_op[k]    <= reset_op(k);
        r_dwell[k] <= DWELL_W'(1);
      end
    end else begin
      r_cfg_err <= cfg_we && !w_cfg_ok;
      if (w_cfg_ok) begin
        r_op[cfg_stage]    <= op_e'(cfg_op);
        r_dwell[cfg_stage] <= cfg_dwell;
      end
    end
  end

  for (genvar g = 0; g < NUM_STAGES; g++) begin : g_stage
    if (g == 0) begin : g_head
      assign w_start[g] = in_valid && w_in_ready;
    end else begin : g_link
      assign w_start[g] = w_ready[g-1] && (w_state[g] == ST_EMPTY);
    end

    // Downstream is free only once it is fully EMPTY, giving one bubble after each drain.
    if (g == NUM_STAGES - 1) begin : g_tail
      assign w_dn_free[g] = out_ready;
    end else begin : g_mid
      assign w_dn_free[g] = (w_state[g+1] == ST_EMPTY);
    end

    chamber_stage_fsm #(
      .DWELL_W (DWELL_W),
      .CNT_W   (CNT_W)
    ) u_fsm (
      .clk             (clk),
      .rst             (rst),
      .start_fill      (w_start[g]),
      .downstream_free (w_dn_free[g]),
      .dwell           (r_dwell[g]),
      .xfer            (XFER_L),
      .state           (w_state[g]),
      .valve           (w_valve[g]),
      .ready           (w_ready[g])
    );

    assign valve_open[g]       = w_valve[g];
    assign stage_busy[g]       = (w_state[g] != ST_EMPTY);
    assign stage_op[2*g +: 2]  = r_op[g];
  end

  assign valve_open[NUM_STAGES] = (w_state[NUM_STAGES-1] == ST_DRAIN);
  assign out_valid = w_ready[NUM_STAGES-1];
  assign in_ready  = w_in_ready;
  assign cfg_err   = r_cfg_err;

endmodule

// File: tb/tb_chamber_chain_sequencer.sv
// Directed bench for chamber_chain_sequencer: config/handshake vector table plus
// hand-written single-plug, backpressure, reset and throughput sequences.
module tb_chamber_chain_sequencer;
  import mfda_seq_pkg::*;

  localparam int N  = 5;
  localparam int DW = 8;
  localparam int X  = 2;
  localparam int SW = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          cfg_we;
  logic [SW-1:0] cfg_stage;
  logic [1:0]    cfg_op;
  logic [DW-1:0] cfg_dwell;
  logic          cfg_err;
  logic          in_valid;
  logic          in_ready;
  logic          out_valid;
  logic          out_ready;
  logic [N:0]    valve_open;
  logic [N-1:0]  stage_busy;
  logic [2*N-1:0] stage_op;

  int total = 0;
  int bad   = 0;
  int dw_arr [N];

  always #5 clk = ~clk;

  chamber_chain_sequencer dut (
    .clk        (clk),
    .rst        (rst),
    .cfg_we     (cfg_we),
    .cfg_stage  (cfg_stage),
    .cfg_op     (cfg_op),
    .cfg_dwell  (cfg_dwell),
    .cfg_err    (cfg_err),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .valve_open (valve_open),
    .stage_busy (stage_busy),
    .stage_op   (stage_op)
  );

  typedef struct {
    logic          we;
    logic [SW-1:0] stg;
    logic [1:0]    op;
    logic [DW-1:0] dw;
    logic          iv;
    logic          e_err;
    logic [2*N-1:0] e_op;
    logic [N-1:0]  e_busy;
    logic          e_irdy;
    logic [N:0]    e_valve;
    logic          e_ov;
  } vec_t;

  vec_t vt [13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; cfg_we = 1'b0;
    tick();
    rst = 1'b0;
    for (int k = 0; k < N; k++) dw_arr[k] = 1;
  endtask

  task automatic cfg_write(input int stg, input int op, input int dw);
    cfg_we = 1'b1; cfg_stage = SW'(stg); cfg_op = 2'(op); cfg_dwell = DW'(dw);
    tick();
    cfg_we = 1'b0;
    dw_arr[stg] = dw;
  endtask

  task automatic single_plug(input string tag, input int exp_lat);
    int f [N];
    int ov_e;
    int lat;
    logic [N:0] ev;
    f[0] = 0;
    for (int k = 1; k < N; k++) f[k] = f[k-1] + X + dw_arr[k-1] + 1;
    ov_e = f[N-1] + X + dw_arr[N-1];
    lat  = -1;
    in_valid = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int n = 0; n <= ov_e + X + 1; n++) begin
      ev = '0;
      for (int k = 0; k < N; k++) ev[k] = (n >= f[k]) && (n < f[k] + X);
      ev[N] = (n > ov_e) && (n <= ov_e + X);
      chk($sformatf("%s.valve@%0d", tag, n), 32'(valve_open), 32'(ev));
      chk($sformatf("%s.ov@%0d", tag, n), 32'(out_valid), 32'(n == ov_e));
      if (out_valid === 1'b1 && lat < 0) lat = n;
      if (n == ov_e + X + 1) chk($sformatf("%s.busy_end", tag), 32'(stage_busy), 32'd0);
      tick();
    end
    chk($sformatf("%s.latency", tag), 32'(lat), 32'(exp_lat));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int rises [$];
    rst = 1'b1; cfg_we = 1'b0; cfg_stage = '0; cfg_op = '0; cfg_dwell = '0;
    in_valid = 1'b0; out_ready = 1'b0;
    for (int k = 0; k < N; k++) dw_arr[k] = 1;

    // reset state
    tick(); tick();
    chk("rst.in_ready", 32'(in_ready), 32'd0);
    chk("rst.busy", 32'(stage_busy), 32'd0);
    chk("rst.valve", 32'(valve_open), 32'd0);
    chk("rst.out_valid", 32'(out_valid), 32'd0);
    chk("rst.cfg_err", 32'(cfg_err), 32'd0);
    chk("rst.op", 32'(stage_op), 32'h0E4);
    rst = 1'b0;
    #1;
    chk("rst.in_ready_after", 32'(in_ready), 32'd1);

    // config guard and first transfers, one vector per clock
    vt[0]  = '{1'b0, 3'd0, 2'd0, 8'd0, 1'b0, 1'b0, 10'h0E4, 5'h00, 1'b1, 6'h00, 1'b0};
    vt[1]  = '{1'b1, 3'd7, 2'd3, 8'd5, 1'b0, 1'b1, 10'h0E4, 5'h00, 1'b1, 6'h00, 1'b0};
    vt[2]  = '{1'b0, 3'd0, 2'd0, 8'd0, 1'b0, 1'b0, 10'h0E4, 5'h00, 1'b1, 6'h00, 1'b0};
    vt[3]  = '{1'b1, 3'd2, 2'd0, 8'd3, 1'b0, 1'b0, 10'h0C4, 5'h00, 1'b1, 6'h00, 1'b0};
    vt[4]  = '{1'b1, 3'd0, 2'd3, 8'd1, 1'b1, 1'b0, 10'h0C7, 5'h01, 1'b0, 6'h01, 1'b0};
    vt[5]  = '{1'b0, 3'd0, 2'd0, 8'd0, 1'b0, 1'b0, 10'h0C7, 5'h01, 1'b0, 6'h01, 1'b0};
    vt[6]  = '{1'b0, 3'd0, 2'd0, 8'd0, 1'b0, 1'b0, 10'h0C7, 5'h01, 1'b0, 6'h00, 1'b0};
    vt[7]  = '{1'b0, 3'd0, 2'd0, 8'd0, 1'b0, 1'b0, 10'h0C7, 5'h01, 1'b0, 6'h00, 1'b0};
    vt[8]  = '{1'b1, 3'd1, 2'd2, 8'd9, 1'b0, 1'b1, 10'h0C7, 5'h03, 1'b0, 6'h02, 1'b0};
    vt[9]  = '{1'b0, 3'd0, 2'd0, 8'd0, 1'b0, 1'b0, 10'h0C7, 5'h03, 1'b0, 6'h02, 1'b0};
    vt[10] = '{1'b0, 3'd0, 2'd0, 8'd0, 1'b0, 1'b0, 10'h0C7, 5'h02, 1'b1, 6'h00, 1'b0};
    vt[11] = '{1'b0, 3'd0, 2'd0, 8'd0, 1'b0, 1'b0, 10'h0C7, 5'h02, 1'b1, 6'h00, 1'b0};
    vt[12] = '{1'b0, 3'd0, 2'd0, 8'd0, 1'b0, 1'b0, 10'h0C7, 5'h06, 1'b1, 6'h04, 1'b0};
    for (int i = 0; i < 13; i++) begin
      cfg_we = vt[i].we; cfg_stage = vt[i].stg; cfg_op = vt[i].op;
      cfg_dwell = vt[i].dw; in_valid = vt[i].iv;
      tick();
      chk($sformatf("vec%0d.cfg_err", i), 32'(cfg_err), 32'(vt[i].e_err));
      chk($sformatf("vec%0d.op", i), 32'(stage_op), 32'(vt[i].e_op));
      chk($sformatf("vec%0d.busy", i), 32'(stage_busy), 32'(vt[i].e_busy));
      chk($sformatf("vec%0d.in_ready", i), 32'(in_ready), 32'(vt[i].e_irdy));
      chk($sformatf("vec%0d.valve", i), 32'(valve_open), 32'(vt[i].e_valve));
      chk($sformatf("vec%0d.out_valid", i), 32'(out_valid), 32'(vt[i].e_ov));
    end
    cfg_we = 1'b0; in_valid = 1'b0;

    // single plug, all dwell 3, then stage 2 dwell 0
    do_reset();
    for (int k = 0; k < N; k++) cfg_write(k, k % 4, 3);
    single_plug("plug_d3", 29);
    cfg_write(2, 2, 0);
    single_plug("plug_d0", 26);

    // backpressure stall and release
    do_reset();
    in_valid = 1'b1; out_ready = 1'b0;
    repeat (100) tick();
    chk("bp.busy_full", 32'(stage_busy), 32'h1F);
    chk("bp.in_ready", 32'(in_ready), 32'd0);
    chk("bp.out_valid", 32'(out_valid), 32'd1);
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("bp.stall_valve%0d", i), 32'(valve_open), 32'd0);
      tick();
    end
    begin
      logic [N:0] rel [7];
      rel[0] = 6'h20; rel[1] = 6'h20; rel[2] = 6'h00; rel[3] = 6'h10;
      rel[4] = 6'h10; rel[5] = 6'h00; rel[6] = 6'h08;
      out_ready = 1'b1;
      for (int i = 0; i < 7; i++) begin
        tick();
        chk($sformatf("bp.release_valve%0d", i), 32'(valve_open), 32'(rel[i]));
      end
    end

    // reset while three plugs are in flight
    do_reset();
    cfg_write(0, 3, 3);
    for (int k = 1; k < N; k++) cfg_write(k, k % 4, 3);
    in_valid = 1'b1; out_ready = 1'b1;
    repeat (25) tick();
    chk("mid.busy", 32'(stage_busy), 32'h1F);
    chk("mid.valve", 32'(valve_open), 32'h12);
    rst = 1'b1;
    #1;
    chk("mid.in_ready_rst", 32'(in_ready), 32'd0);
    tick();
    chk("mid.busy_rst", 32'(stage_busy), 32'd0);
    chk("mid.valve_rst", 32'(valve_open), 32'd0);
    chk("mid.ov_rst", 32'(out_valid), 32'd0);
    chk("mid.err_rst", 32'(cfg_err), 32'd0);
    chk("mid.op_rst", 32'(stage_op), 32'h0E4);
    chk("mid.in_ready_in_rst", 32'(in_ready), 32'd0);
    rst = 1'b0; in_valid = 1'b0;
    for (int k = 0; k < N; k++) dw_arr[k] = 1;
    #1;
    chk("mid.in_ready_after", 32'(in_ready), 32'd1);
    single_plug("plug_default", 19);

    // throughput with continuous injection
    do_reset();
    for (int k = 0; k < N; k++) cfg_write(k, k % 4, 3);
    in_valid = 1'b1; out_ready = 1'b1;
    for (int n = 0; n < 80; n++) begin
      tick();
      if (out_valid === 1'b1) rises.push_back(n);
    end
    in_valid = 1'b0;
    chk("tp.count", 32'(rises.size()), 32'd6);
    if (rises.size() > 0) chk("tp.first", 32'(rises[0]), 32'd29);
    for (int i = 1; i < rises.size(); i++)
      chk($sformatf("tp.spacing%0d", i), 32'(rises[i] - rises[i-1]), 32'd9);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
